// File: rtl/npc_pkg.sv
//============================================================================
// npc_pkg: ALU operation codes, RV32I opcodes, immediate selects, IDU states.
// Rev 1.0
//============================================================================
`default_nettype none

package npc_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_JALR  = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_AND   = 5'b00111;
  localparam logic [4:0] ALU_SLL   = 5'b01000;
  localparam logic [4:0] ALU_SRA   = 5'b01001;
  localparam logic [4:0] ALU_SRL   = 5'b01010;
  localparam logic [4:0] ALU_SLT   = 5'b01100;
  localparam logic [4:0] ALU_BEQ   = 5'b01101;
  localparam logic [4:0] ALU_BGE   = 5'b01110;
  localparam logic [4:0] ALU_BGEU  = 5'b01111;
  localparam logic [4:0] ALU_BLT   = 5'b10000;
  localparam logic [4:0] ALU_BLTU  = 5'b10001;
  localparam logic [4:0] ALU_BNE   = 5'b10010;
  localparam logic [4:0] ALU_SLLI  = 5'b10011;
  localparam logic [4:0] ALU_SRAI  = 5'b10100;
  localparam logic [4:0] ALU_SRLI  = 5'b10101;
  localparam logic [4:0] ALU_CSRRS = 5'b10110;
  localparam logic [4:0] ALU_CSRRW = 5'b10111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DRAIN  = 2'd3
  } idu_state_e;

endpackage

`default_nettype wire

// File: rtl/idu_imm_gen.sv
//============================================================================
// idu_imm_gen: combinational RV32I I/S/B/U/J immediate extraction.
// Rev 1.0
//============================================================================
`default_nettype none

module idu_imm_gen
  import npc_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
    case (sel_i)
      IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idu_issue.sv
//============================================================================
// idu_issue: RV32I decode/issue stage with IDU_done/ALU_done handshake.
// Optional Zicsr (csrrw/csrrs) enabled by defining IDU_ZICSR_EN. Rev 1.0
//============================================================================
`default_nettype none

module idu_issue
  import npc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_valid,
  output logic              ifu_ready,
  input  logic [31:0]       inst_in,
  input  logic [XLEN-1:0]   pc_in,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [11:0]       csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [31:0]       instruction,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2,
  output logic [XLEN-1:0]   csr_input,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              IDU_done,
  input  logic              ALU_done,
  output logic [4:0]        rd_addr,
  output logic              rd_we,
  output logic              illegal
);

  idu_state_e        state_q, state_d;
  logic [31:0]       inst_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   src1_q, src2_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_q;
  logic              we_q;

  logic [6:0]        w_opcode, w_funct7;
  logic [2:0]        w_funct3;
  logic [4:0]        w_rd;
  logic [2:0]        w_imm_sel;
  logic [XLEN-1:0]   w_imm;

  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_src1, dec_src2;
  logic              dec_we, dec_ill, w_rd_we;

  assign w_opcode = inst_q[6:0];
  assign w_rd     = inst_q[11:7];
  assign w_funct3 = inst_q[14:12];
  assign w_funct7 = inst_q[31:25];
  assign rs1_addr = inst_q[19:15];
  assign rs2_addr = inst_q[24:20];

  // Select depends on opcode only, keeping it off the decode loop.
  always_comb begin
    w_imm_sel = IMM_I;
    case (w_opcode)
      OPC_STORE:          w_imm_sel = IMM_S;
      OPC_BRANCH:         w_imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC: w_imm_sel = IMM_U;
      OPC_JAL:            w_imm_sel = IMM_J;
      default: ;
    endcase
  end

  idu_imm_gen u_imm_gen (
    .inst_i (inst_q),
    .sel_i  (w_imm_sel),
    .imm_o  (w_imm)
  );

`ifdef IDU_ZICSR_EN
  logic [XLEN-1:0] dec_csr, csr_q;
  assign csr_addr = inst_q[31:20];
`else
  assign csr_addr = 12'b0;
`endif

  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_src1 = rs1_data;
    dec_src2 = rs2_data;
    dec_we   = 1'b0;
    dec_ill  = 1'b0;
`ifdef IDU_ZICSR_EN
    dec_csr  = '0;
`endif
    case (w_opcode)
      OPC_OP: begin
        dec_we = 1'b1;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000: dec_ctrl = ALU_ADD;
            3'b001: dec_ctrl = ALU_SLL;
            3'b010: dec_ctrl = ALU_SLT;
            3'b011: dec_ctrl = ALU_SLTU;
            3'b100: dec_ctrl = ALU_XOR;
            3'b101: dec_ctrl = ALU_SRL;
            3'b110: dec_ctrl = ALU_OR;
            default: dec_ctrl = ALU_AND;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          dec_ctrl = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          dec_ctrl = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_we   = 1'b1;
        dec_src2 = w_imm;
        case (w_funct3)
          3'b000: dec_ctrl = ALU_ADD;
          3'b010: dec_ctrl = ALU_SLT;
          3'b011: dec_ctrl = ALU_SLTU;
          3'b100: dec_ctrl = ALU_XOR;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
          default: begin
            // Shifts: shamt zero-extended, funct7 selects logical/arith.
            dec_src2 = {{(XLEN-5){1'b0}}, inst_q[24:20]};
            if (w_funct3 == 3'b001 && w_funct7 == F7_BASE)
              dec_ctrl = ALU_SLLI;
            else if (w_funct3 == 3'b101 && w_funct7 == F7_BASE)
              dec_ctrl = ALU_SRLI;
            else if (w_funct3 == 3'b101 && w_funct7 == F7_ALT)
              dec_ctrl = ALU_SRAI;
            else
              dec_ill = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec_ctrl = ALU_LUI;
        dec_src1 = '0;
        dec_src2 = w_imm;
        dec_we   = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec_src1 = pc_q;
        dec_src2 = w_imm;
        dec_we   = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl = ALU_JALR;
        dec_src2 = w_imm;
        dec_we   = 1'b1;
        dec_ill  = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        case (w_funct3)
          3'b000: dec_ctrl = ALU_BEQ;
          3'b001: dec_ctrl = ALU_BNE;
          3'b100: dec_ctrl = ALU_BLT;
          3'b101: dec_ctrl = ALU_BGE;
          3'b110: dec_ctrl = ALU_BLTU;
          3'b111: dec_ctrl = ALU_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_src2 = w_imm;
        dec_we   = 1'b1;
        dec_ill  = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec_src2 = w_imm;
        dec_ill  = (w_funct3[2] || w_funct3[1:0] == 2'b11);
      end
      OPC_SYSTEM: begin
        dec_src1 = '0;
        dec_src2 = '0;
        if (w_funct3 == 3'b000) begin
          // Only ecall (imm 0) and ebreak (imm 1) with zero rs1/rd.
          dec_ill = (inst_q[31:21] != 11'b0) || (inst_q[19:7] != 13'b0);
        end else begin
`ifdef IDU_ZICSR_EN
          dec_src1 = rs1_data;
          dec_csr  = csr_rdata;
          dec_we   = 1'b1;
          if (w_funct3 == 3'b001)
            dec_ctrl = ALU_CSRRW;
          else if (w_funct3 == 3'b010)
            dec_ctrl = ALU_CSRRS;
          else
            dec_ill = 1'b1;
`else
          dec_ill = 1'b1;
`endif
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign w_rd_we = dec_we && (w_rd != 5'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ifu_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_ill ? ST_IDLE : ST_ISSUE;
      ST_ISSUE:  if (ALU_done) state_d = ST_DRAIN;
      ST_DRAIN:  if (!ALU_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      pc_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && ifu_valid) begin
        inst_q <= inst_in;
        pc_q   <= pc_in;
      end
      if (state_q == ST_DECODE) begin
        if (dec_ill) begin
          rd_q <= '0;
          we_q <= 1'b0;
        end else begin
          src1_q <= dec_src1;
          src2_q <= dec_src2;
          ctrl_q <= dec_ctrl;
          rd_q   <= w_rd_we ? w_rd : 5'd0;
          we_q   <= w_rd_we;
        end
      end
    end
  end

`ifdef IDU_ZICSR_EN
  always_ff @(posedge clk) begin
    if (rst)
      csr_q <= '0;
    else if (state_q == ST_DECODE && !dec_ill)
      csr_q <= dec_csr;
  end
  assign csr_input = csr_q;
`else
  logic unused_csr_rdata;
  assign unused_csr_rdata = ^csr_rdata;
  assign csr_input        = '0;
`endif

  assign ifu_ready   = (state_q == ST_IDLE);
  assign IDU_done    = (state_q == ST_ISSUE);
  assign illegal     = (state_q == ST_DECODE) && dec_ill;
  assign instruction = inst_q;
  assign src1        = src1_q;
  assign src2        = src2_q;
  assign alu_ctrl    = ctrl_q;
  assign rd_addr     = rd_q;
  assign rd_we       = we_q;

endmodule

`default_nettype wire

// File: tb/tb_idu_issue.sv
//============================================================================
// tb_idu_issue: randomized self-checking bench for idu_issue against an
// instruction-level reference model. Rev 1.0
//============================================================================
`default_nettype none

module tb_idu_issue;

  localparam logic [3:0] F_R = 4'd0, F_I = 4'd1, F_SH = 4'd2, F_LUI = 4'd3,
                         F_AUIPC = 4'd4, F_J = 4'd5, F_JALR = 4'd6, F_B = 4'd7,
                         F_L = 4'd8, F_S = 4'd9, F_SYS = 4'd10, F_CSR = 4'd11;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03,
                         OP_ST = 7'h23, OP_SYS = 7'h73;
  localparam int N_OPS = 41;

  typedef struct packed {
    logic [3:0] fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] ctrl;
  } opi_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
  } desc_t;

  typedef struct packed {
    logic        ill;
    logic [4:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] csr;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ifu_valid, ifu_ready, IDU_done, ALU_done, rd_we, illegal;
  logic [31:0] inst_in, pc_in, rs1_data, rs2_data, csr_rdata, instruction;
  logic [31:0] src1, src2, csr_input;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, alu_ctrl;
  logic [11:0] csr_addr;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign rs1_data  = rf[rs1_addr];
  assign rs2_data  = rf[rs2_addr];
  assign csr_rdata = csr_model(csr_addr);

  idu_issue dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .inst_in(inst_in), .pc_in(pc_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_addr(csr_addr),
    .csr_rdata(csr_rdata), .instruction(instruction), .src1(src1), .src2(src2),
    .csr_input(csr_input), .alu_ctrl(alu_ctrl), .IDU_done(IDU_done),
    .ALU_done(ALU_done), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
  );

  function automatic logic [31:0] csr_model(input logic [11:0] a);
    return {20'hC5A3C, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic opi_t mk(input logic [3:0] fmt, input logic [6:0] opc,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] ctrl);
    opi_t o;
    o.fmt = fmt; o.opc = opc; o.f3 = f3; o.f7 = f7; o.ctrl = ctrl;
    return o;
  endfunction

  // Instruction table: format, encoding fields and the ALU code the spec assigns.
  function automatic opi_t op_info(input int idx);
    case (idx)
      0:  return mk(F_R, OP_R, 3'b000, 7'h00, 5'b00000);
      1:  return mk(F_R, OP_R, 3'b000, 7'h20, 5'b00010);
      2:  return mk(F_R, OP_R, 3'b100, 7'h00, 5'b00101);
      3:  return mk(F_R, OP_R, 3'b110, 7'h00, 5'b00110);
      4:  return mk(F_R, OP_R, 3'b111, 7'h00, 5'b00111);
      5:  return mk(F_R, OP_R, 3'b001, 7'h00, 5'b01000);
      6:  return mk(F_R, OP_R, 3'b101, 7'h00, 5'b01010);
      7:  return mk(F_R, OP_R, 3'b101, 7'h20, 5'b01001);
      8:  return mk(F_R, OP_R, 3'b010, 7'h00, 5'b01100);
      9:  return mk(F_R, OP_R, 3'b011, 7'h00, 5'b00100);
      10: return mk(F_I, OP_I, 3'b000, 7'h00, 5'b00000);
      11: return mk(F_I, OP_I, 3'b100, 7'h00, 5'b00101);
      12: return mk(F_I, OP_I, 3'b110, 7'h00, 5'b00110);
      13: return mk(F_I, OP_I, 3'b111, 7'h00, 5'b00111);
      14: return mk(F_I, OP_I, 3'b010, 7'h00, 5'b01100);
      15: return mk(F_I, OP_I, 3'b011, 7'h00, 5'b00100);
      16: return mk(F_SH, OP_I, 3'b001, 7'h00, 5'b10011);
      17: return mk(F_SH, OP_I, 3'b101, 7'h00, 5'b10101);
      18: return mk(F_SH, OP_I, 3'b101, 7'h20, 5'b10100);
      19: return mk(F_LUI, OP_LUI, 3'b000, 7'h00, 5'b00001);
      20: return mk(F_AUIPC, OP_AUIPC, 3'b000, 7'h00, 5'b00000);
      21: return mk(F_J, OP_JAL, 3'b000, 7'h00, 5'b00000);
      22: return mk(F_JALR, OP_JALR, 3'b000, 7'h00, 5'b00011);
      23: return mk(F_B, OP_BR, 3'b000, 7'h00, 5'b01101);
      24: return mk(F_B, OP_BR, 3'b001, 7'h00, 5'b10010);
      25: return mk(F_B, OP_BR, 3'b100, 7'h00, 5'b10000);
      26: return mk(F_B, OP_BR, 3'b101, 7'h00, 5'b01110);
      27: return mk(F_B, OP_BR, 3'b110, 7'h00, 5'b10001);
      28: return mk(F_B, OP_BR, 3'b111, 7'h00, 5'b01111);
      29: return mk(F_L, OP_LD, 3'b000, 7'h00, 5'b00000);
      30: return mk(F_L, OP_LD, 3'b001, 7'h00, 5'b00000);
      31: return mk(F_L, OP_LD, 3'b010, 7'h00, 5'b00000);
      32: return mk(F_L, OP_LD, 3'b100, 7'h00, 5'b00000);
      33: return mk(F_L, OP_LD, 3'b101, 7'h00, 5'b00000);
      34: return mk(F_S, OP_ST, 3'b000, 7'h00, 5'b00000);
      35: return mk(F_S, OP_ST, 3'b001, 7'h00, 5'b00000);
      36: return mk(F_S, OP_ST, 3'b010, 7'h00, 5'b00000);
      37: return mk(F_SYS, OP_SYS, 3'b000, 7'h00, 5'b00000);
      38: return mk(F_SYS, OP_SYS, 3'b000, 7'h00, 5'b00000);
      39: return mk(F_CSR, OP_SYS, 3'b001, 7'h00, 5'b10111);
      default: return mk(F_CSR, OP_SYS, 3'b010, 7'h00, 5'b10110);
    endcase
  endfunction

  function automatic logic [31:0] encode(input desc_t d);
    opi_t o;
    logic [19:0] r;
    o = op_info(int'(d.op));
    r = d.imm;
    case (o.fmt)
      F_R:            return {o.f7, d.rs2, d.rs1, o.f3, d.rd, o.opc};
      F_SH:           return {o.f7, r[4:0], d.rs1, o.f3, d.rd, o.opc};
      F_LUI, F_AUIPC: return {r, d.rd, o.opc};
      F_J:            return {r[19], r[9:0], r[10], r[18:11], d.rd, o.opc};
      F_B:            return {r[11], r[9:4], d.rs2, d.rs1, o.f3, r[3:0], r[10], o.opc};
      F_S:            return {r[11:5], d.rs2, d.rs1, o.f3, r[4:0], o.opc};
      F_SYS:          return {r[11:0], 5'd0, 3'b000, 5'd0, o.opc};
      default:        return {r[11:0], d.rs1, o.f3, d.rd, o.opc};
    endcase
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    int x;
    x = int'(v);
    if (x >= 2048) x -= 4096;
    return 32'(x);
  endfunction

  function automatic exp_t model(input desc_t d, input logic [31:0] pc);
    exp_t e;
    opi_t o;
    int   j;
    o = op_info(int'(d.op));
    e = '0;
    e.ctrl = o.ctrl;
    e.s1 = rf[d.rs1];
    e.we = 1'b1;
    case (o.fmt)
      F_R:            e.s2 = rf[d.rs2];
      F_I, F_JALR, F_L: e.s2 = sext12(d.imm[11:0]);
      F_SH:           e.s2 = 32'(d.imm[4:0]);
      F_LUI:   begin e.s1 = 0; e.s2 = 32'(d.imm) * 32'd4096; end
      F_AUIPC: begin e.s1 = pc; e.s2 = 32'(d.imm) * 32'd4096; end
      F_J: begin
        j = int'(d.imm);
        if (j >= 524288) j -= 1048576;
        e.s1 = pc;
        e.s2 = 32'(j * 2);
      end
      F_B:     begin e.s2 = rf[d.rs2]; e.we = 1'b0; end
      F_S:     begin e.s2 = sext12(d.imm[11:0]); e.we = 1'b0; end
      F_SYS:   begin e.s1 = 0; e.s2 = 0; e.we = 1'b0; end
      default: begin
`ifdef IDU_ZICSR_EN
        e.s2  = 0;
        e.csr = csr_model(d.imm[11:0]);
`else
        e.ill = 1'b1;
`endif
      end
    endcase
    if (o.fmt == F_B || o.fmt == F_S) e.rd = 0;
    else e.rd = d.rd;
    if (!e.we || e.rd == 0) begin e.we = 1'b0; e.rd = 0; end
    return e;
  endfunction

  task automatic check_ops(input string tag, input exp_t e, input logic [31:0] word);
    check_eq({tag, ".done"}, 32'(IDU_done), 32'd1);
    check_eq({tag, ".src1"}, src1, e.s1);
    check_eq({tag, ".src2"}, src2, e.s2);
    check_eq({tag, ".ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
    check_eq({tag, ".rd"}, 32'(rd_addr), 32'(e.rd));
    check_eq({tag, ".we"}, 32'(rd_we), 32'(e.we));
    check_eq({tag, ".csr"}, csr_input, e.csr);
    check_eq({tag, ".inst"}, instruction, word);
  endtask

  // One instruction through accept, decode, issue (ALU_done after dly
  // cycles), and drain (ALU_done held extra cycles past IDU_done falling).
  task automatic run_txn(input logic [31:0] word, input logic [31:0] pc, input exp_t e,
                         input int dly, input int extra, input bit abort);
    if (ifu_ready !== 1'b1) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    ifu_valid = 1'b1;
    inst_in   = word;
    pc_in     = pc;
    @(negedge clk);
    ifu_valid = 1'b0;
    inst_in   = $urandom;
    pc_in     = $urandom;
    check_eq("dec.illegal", 32'(illegal), 32'(e.ill));
    check_eq("dec.done", 32'(IDU_done), 32'd0);
    check_eq("dec.ready", 32'(ifu_ready), 32'd0);
    @(negedge clk);
    if (e.ill) begin
      check_eq("ill.pulse_end", 32'(illegal), 32'd0);
      check_eq("ill.done", 32'(IDU_done), 32'd0);
      check_eq("ill.ready", 32'(ifu_ready), 32'd1);
      return;
    end
    check_ops("issue", e, word);
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort.done", 32'(IDU_done), 32'd0);
      check_eq("abort.ready", 32'(ifu_ready), 32'd1);
      check_eq("abort.src1", src1, 32'd0);
      check_eq("abort.we", 32'(rd_we), 32'd0);
      return;
    end
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check_ops("hold", e, word);
    end
    ALU_done = 1'b1;
    @(negedge clk);
    check_eq("drain.done", 32'(IDU_done), 32'd0);
    check_eq("drain.ready", 32'(ifu_ready), 32'd0);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      check_eq("stale.done", 32'(IDU_done), 32'd0);
      check_eq("stale.ready", 32'(ifu_ready), 32'd0);
    end
    ALU_done = 1'b0;
    @(negedge clk);
    check_eq("idle.ready", 32'(ifu_ready), 32'd1);
  endtask

  task automatic run_desc(input desc_t d, input int dly, input int extra, input bit abort);
    logic [31:0] pc;
    exp_t        e;
    pc = $urandom & 32'hFFFF_FFFC;
    e  = model(d, pc);
    run_txn(encode(d), pc, e, dly, extra, abort);
  endtask

  task automatic run_illegal(input logic [31:0] word);
    exp_t e;
    e = '0;
    e.ill = 1'b1;
    run_txn(word, 32'h0000_1000, e, 0, 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d;
    rst = 1'b1; ifu_valid = 1'b0; ALU_done = 1'b0; inst_in = '0; pc_in = '0;
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    repeat (3) @(negedge clk);
    check_eq("rst.ready", 32'(ifu_ready), 32'd1);
    check_eq("rst.done", 32'(IDU_done), 32'd0);
    check_eq("rst.we", 32'(rd_we), 32'd0);
    check_eq("rst.illegal", 32'(illegal), 32'd0);
    check_eq("rst.src1", src1, 32'd0);
    check_eq("rst.src2", src2, 32'd0);
    check_eq("rst.ctrl", 32'(alu_ctrl), 32'd0);
    check_eq("rst.inst", instruction, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // addi x1,x2,-5 with x2=10, slow ALU then lingering ALU_done
    rf[2] = 32'd10;
    d = '{op: 6'd10, rd: 5'd1, rs1: 5'd2, rs2: 5'd0, imm: 20'h00FFB};
    run_desc(d, 3, 2, 1'b0);
    d = '{op: 6'd18, rd: 5'd3, rs1: 5'd4, rs2: 5'd0, imm: 20'd7};
    run_desc(d, 0, 0, 1'b0);
    d = '{op: 6'd24, rd: 5'd9, rs1: 5'd5, rs2: 5'd6, imm: 20'h00123};
    run_desc(d, 1, 0, 1'b0);
    d = '{op: 6'd40, rd: 5'd7, rs1: 5'd5, rs2: 5'd0, imm: 20'h00300};
    run_desc(d, 0, 1, 1'b0);
    d = '{op: 6'd0, rd: 5'd0, rs1: 5'd8, rs2: 5'd9, imm: 20'd0};
    run_desc(d, 0, 0, 1'b0);
    d = '{op: 6'd0, rd: 5'd12, rs1: 5'd8, rs2: 5'd9, imm: 20'd0};
    run_desc(d, 2, 0, 1'b1);

    run_illegal(32'hFFFF_FFFF);
    run_illegal(32'h0000_0000);
    run_illegal({7'h01, 5'd3, 5'd2, 3'b000, 5'd1, OP_R});
    run_illegal({7'h20, 5'd3, 5'd2, 3'b001, 5'd1, OP_R});
    run_illegal({7'h00, 5'd1, 5'd2, 3'b010, 5'd0, OP_BR});
    run_illegal({12'h010, 5'd2, 3'b011, 5'd3, OP_LD});
    run_illegal({12'h010, 5'd2, 3'b011, 5'd3, OP_ST});
    run_illegal({12'h004, 5'd2, 3'b001, 5'd3, OP_JALR});
    run_illegal({7'h20, 5'd3, 5'd2, 3'b001, 5'd1, OP_I});
    run_illegal({12'h300, 5'd1, 3'b100, 5'd2, OP_SYS});

    for (int n = 0; n < 200; n++) begin
      d.op  = 6'($urandom_range(0, N_OPS - 1));
      d.rd  = 5'($urandom);
      d.rs1 = 5'($urandom);
      d.rs2 = 5'($urandom);
      d.imm = 20'($urandom);
      if (d.op == 6'd37 || d.op == 6'd38) begin
        d.rd  = 0;
        d.rs1 = 0;
        d.imm = (d.op == 6'd38) ? 20'd1 : 20'd0;
      end
      run_desc(d, $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
